// File: rtl/int_vector_ctrl.sv
// Redirect source for yChip: issues the boot redirect after reset, then arbitrates
// timer and external interrupts into one-cycle INT pulses with the handler vector.
module int_vector_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h28,
  parameter logic [31:0] TIMER_VEC = 32'h100,
  parameter logic [31:0] EXT_VEC   = 32'h180,
  parameter int          TW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [TW-1:0] timer_period,
  input  logic          timer_en,
  input  logic          irq_ext,
  input  logic          mask_wr,
  input  logic [1:0]    mask_in,
  input  logic          iret,
  output logic [31:0]   entryPoint,
  output logic          INT,
  output logic [1:0]    pending,
  output logic          in_service
);

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_FIRE, S_SERVICE} state_e;

  state_e        state_q, state_d;
  logic          int_q, int_d;
  logic [31:0]   entry_q, entry_d;
  logic [1:0]    pending_q, pending_d;
  logic [1:0]    mask_q, mask_d;
  logic [TW-1:0] count_q, count_d;
  logic          in_service_q, in_service_d;
  logic          irq_q;
  logic [1:0]    clr;
  logic          timer_hit;
  logic          ext_rise;

  // NOTE: every variable written in an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    int_d        = 1'b0;
    entry_d      = entry_q;
    in_service_d = in_service_q;
    clr          = 2'b00;
    case (state_q)
      S_BOOT: state_d = S_IDLE;
      S_IDLE: begin
        // Arbitration sees the mask as it was before this edge; timer wins ties.
        if (|(pending_q & mask_q)) begin
          state_d = S_FIRE;
          int_d   = 1'b1;
          if (pending_q[0] && mask_q[0]) begin
            entry_d = TIMER_VEC;
            clr     = 2'b01;
          end else begin
            entry_d = EXT_VEC;
            clr     = 2'b10;
          end
        end
      end
      S_FIRE: begin
        state_d      = S_SERVICE;
        in_service_d = 1'b1;
      end
      S_SERVICE: begin
        if (iret) begin
          state_d      = S_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    timer_hit = 1'b0;
    if (timer_en && (timer_period != '0) && (state_q != S_BOOT)) begin
      if (count_q == timer_period - TW'(1)) begin
        count_d   = '0;
        timer_hit = 1'b1;
      end else begin
        count_d = count_q + TW'(1);
      end
    end
  end

  // A fresh event on the same edge as the clear must survive, so set is OR-ed last.
  assign ext_rise  = irq_ext & ~irq_q;
  assign pending_d = (pending_q & ~clr) | {ext_rise, timer_hit};
  assign mask_d    = mask_wr ? mask_in : mask_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_BOOT;
      int_q        <= 1'b1;
      entry_q      <= BOOT_ADDR;
      pending_q    <= 2'b00;
      mask_q       <= 2'b00;
      count_q      <= '0;
      in_service_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      int_q        <= int_d;
      entry_q      <= entry_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      count_q      <= count_d;
      in_service_q <= in_service_d;
      irq_q        <= irq_ext;
    end
  end

  assign entryPoint = entry_q;
  assign INT        = int_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
